iter_div_chain: RTL and testbench
=================================

ITER_DIV_CHAIN -- requirements
Module: iter_div_chain

Interface
REQ-001 Parameter WIDTH, default 10, operand/accumulator bit width (>=2).
REQ-002 Parameter NUM_OPS, default 48, number of divisor slices applied per transaction (>=1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  transaction request.
REQ-006 in_ready  output  1  block can accept a transaction.
REQ-007 init_val  input  WIDTH  initial accumulator (dividend) value.
REQ-008 divs  input  NUM_OPS*WIDTH  divisor slices; slice k = divs[k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 result  output  WIDTH  final quotient.
REQ-012 div_zero  output  1  at least one divisor slice of this transaction was zero.

Function
REQ-013 Computation SHALL be acc = init_val, then for k = 0..NUM_OPS-1 in ascending order, acc = acc / slice k (unsigned integer division, truncating); result = final acc.
REQ-014 Division by zero SHALL yield quotient all-ones (2^WIDTH-1), SHALL set div_zero, and processing SHALL continue with the next slice.
REQ-015 FSM states SHALL be IDLE, DIV, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept = in_valid && in_ready; on accept, init_val and divs SHALL be captured into internal registers, op index cleared, div_zero cleared, state -> DIV.
REQ-018 Inputs init_val/divs SHALL be ignored outside the accept cycle.
REQ-019 Each slice SHALL be divided by a restoring shift-subtract algorithm, one quotient bit per cycle, exactly WIDTH cycles per slice, including zero divisors.
REQ-020 After the last bit of slice NUM_OPS-1, state -> DONE; out_valid SHALL rise exactly NUM_OPS*WIDTH cycles after the accept edge.
REQ-021 In DONE, result and div_zero SHALL be held stable until out_valid && out_ready; then state -> IDLE.
REQ-022 No new transaction SHALL be accepted in the cycle the result is consumed (one IDLE cycle minimum between transactions).
REQ-023 Internal remainder register SHALL be WIDTH+1 bits to avoid overflow on subtract.
REQ-024 result SHALL only change on the cycle entering DONE.

Reset
REQ-025 While rst=1 at a clock edge: state -> IDLE, result=0, div_zero=0, out_valid=0, in_ready=1 after the edge, all counters and datapath registers cleared.
REQ-026 Reset asserted during DIV or DONE SHALL abort the transaction with no output handshake.

Structure
REQ-027 A shared package SHALL hold the FSM state enum and the divide-by-zero quotient constant function of WIDTH.
REQ-028 One sub-module, iter_div_unit (single-operand WIDTH-cycle restoring divider with start/done), SHALL be instantiated once; iter_div_chain sequences slices through it.
REQ-029 Design SHALL be purely synchronous, no latches, no combinational "/" operator.

Verification
REQ-030 Defaults, init_val=1000, all slices=1 -> result=1000, div_zero=0, out_valid exactly 480 cycles after accept.
REQ-031 NUM_OPS=3, init_val=1000, slices (0,1,2)=(2,4,5) -> result=25, div_zero=0, latency 30 cycles.
REQ-032 NUM_OPS=3, init_val=7, slices=(0,3,1) -> slice0 gives 1023, final result=341, div_zero=1.
REQ-033 NUM_OPS=3, init_val=3, slices=(9,1,1) -> result=0, div_zero=0.
REQ-034 Hold out_ready=0 for 20 cycles in DONE with in_valid=1 and changing divs -> result/div_zero stable, in_ready=0, no accept; out_ready=1 -> IDLE next cycle, next accept one cycle later.
REQ-035 Assert rst mid-DIV (cycle 100 of default run) -> next cycle IDLE, out_valid=0, result=0, div_zero=0; subsequent transaction from REQ-030 completes correctly.

Source files
------------

// File: rtl/iter_div_chain_pkg.sv
// Shared definitions for the iterative divider chain.
//   state_t   : control FSM states (IDLE / DIV / DONE)
//   div0_quot : quotient produced for a zero divisor (all-ones of width w)
package iter_div_chain_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] div0_quot(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/iter_div_unit.sv
// Single-operand restoring divider, one quotient bit per clock, WIDTH clocks
// per operation (zero divisors included).
//   clk, rst : clock, synchronous active-high reset
//   start    : first step of a new division; din/dvs sampled this cycle
//   din, dvs : dividend, divisor
//   done     : high during the cycle whose edge completes the last bit
//   quot     : quotient valid while done is high
//   dz       : divisor of the current step is zero
// The step performed on the start edge already uses din/dvs directly, so the
// caller can chain back-to-back operations with no idle cycle between them.
module iter_div_unit #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] dvs,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic             dz
);

  localparam int            CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);

  // remainder is one bit wider than the operands so the trial subtract
  // exposes its borrow in the MSB
  logic [WIDTH:0]   rem, r_cur, r_sh, diff, r_nxt;
  logic [WIDTH-1:0] qreg, q_cur, q_nxt, dvs_r, d_cur;
  logic [CW-1:0]    cnt, c_cur;
  logic             busy, act;
  logic             unused_msb;

  always_comb begin
    act   = start | busy;
    r_cur = start ? '0  : rem;
    q_cur = start ? din : qreg;
    d_cur = start ? dvs : dvs_r;
    c_cur = start ? '0  : cnt;
    r_sh  = {r_cur[WIDTH-1:0], q_cur[WIDTH-1]};
    diff  = r_sh - {1'b0, d_cur};
    if (diff[WIDTH]) begin
      r_nxt = r_sh;                      // borrow: restore
      q_nxt = {q_cur[WIDTH-2:0], 1'b0};
    end else begin
      r_nxt = diff;
      q_nxt = {q_cur[WIDTH-2:0], 1'b1};
    end
    done = act && (c_cur == CLAST);
  end

  assign quot       = q_nxt;
  assign dz         = (d_cur == '0);
  assign unused_msb = rem[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      qreg  <= '0;
      dvs_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (act) begin
      rem   <= r_nxt;
      qreg  <= q_nxt;
      dvs_r <= d_cur;
      cnt   <= c_cur + 1'b1;
      busy  <= !done;
    end
  end

endmodule

// File: rtl/iter_div_chain.sv
// Divides an accumulator by NUM_OPS divisor slices in ascending order,
// sequencing each slice through one shared restoring divider.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only in IDLE)
//   init_val             : starting dividend
//   divs                 : slice k = divs[k*WIDTH +: WIDTH]
//   out_valid / out_ready: result handshake (valid only in DONE)
//   result               : final quotient, updated only on entering DONE
//   div_zero             : some slice of this transaction was zero
// Slices run back to back, so out_valid rises NUM_OPS*WIDTH cycles after
// the accept edge.
module iter_div_chain
  import iter_div_chain_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int NUM_OPS = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         init_val,
  input  logic [NUM_OPS*WIDTH-1:0] divs,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     div_zero
);

  localparam int               OW    = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [OW-1:0]    OLAST = OW'(NUM_OPS - 1);
  localparam logic [WIDTH-1:0] DZQ   = WIDTH'(div0_quot(WIDTH));

  state_t                          state;
  logic [NUM_OPS-1:0][WIDTH-1:0]   divs_r;
  logic [WIDTH-1:0]                acc, res_r, u_q, q_eff;
  logic [OW-1:0]                   op;
  logic                            dz_r, go, u_done, u_dz;

  iter_div_unit #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (go),
    .din   (acc),
    .dvs   (divs_r[op]),
    .done  (u_done),
    .quot  (u_q),
    .dz    (u_dz)
  );

  assign q_eff     = u_dz ? DZQ : u_q;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign result    = res_r;
  assign div_zero  = dz_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      divs_r <= '0;
      acc    <= '0;
      res_r  <= '0;
      op     <= '0;
      dz_r   <= 1'b0;
      go     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          divs_r <= divs;
          acc    <= init_val;
          op     <= '0;
          dz_r   <= 1'b0;
          go     <= 1'b1;
          state  <= S_DIV;
        end
        S_DIV: begin
          go <= 1'b0;
          if (u_done) begin
            acc  <= q_eff;
            dz_r <= dz_r | u_dz;
            if (op == OLAST) begin
              res_r <= q_eff;
              state <= S_DONE;
            end else begin
              op <= op + 1'b1;
              go <= 1'b1;               // next slice starts on the next edge
            end
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_chain.sv
module tb_iter_div_chain;

  logic         clk = 1'b0;
  logic         rst0, iv0, or0, ir0, ov0, dz0;
  logic [9:0]   init0, res0;
  logic [479:0] divs0;
  logic         rst3, iv3, or3, ir3, ov3, dz3;
  logic [9:0]   init3, res3;
  logic [29:0]  divs3;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  iter_div_chain u0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .init_val(init0),
    .divs(divs0), .out_valid(ov0), .out_ready(or0), .result(res0), .div_zero(dz0)
  );

  iter_div_chain #(.WIDTH(10), .NUM_OPS(3)) u3 (
    .clk(clk), .rst(rst3), .in_valid(iv3), .in_ready(ir3), .init_val(init3),
    .divs(divs3), .out_valid(ov3), .out_ready(or3), .result(res3), .div_zero(dz3)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference: plain integer division, zero divisor -> 1023 and flag
  function automatic void model(input int init, input logic [479:0] d, input int n,
                                output int r, output int z);
    int s;
    r = init;
    z = 0;
    for (int k = 0; k < n; k++) begin
      s = int'(d[k*10 +: 10]);
      if (s == 0) begin r = 1023; z = 1; end
      else r = r / s;
    end
  endfunction

  function automatic logic [479:0] pk3(input int a, input int b, input int c);
    logic [479:0] d;
    d = '0;
    d[9:0] = 10'(a); d[19:10] = 10'(b); d[29:20] = 10'(c);
    return d;
  endfunction

  function automatic logic [479:0] ones48();
    logic [479:0] d;
    for (int k = 0; k < 48; k++) d[k*10 +: 10] = 10'd1;
    return d;
  endfunction

  function automatic logic [479:0] rnd48();
    logic [479:0] d;
    int s;
    for (int k = 0; k < 48; k++) begin
      s = int'($urandom_range(0, 19));
      d[k*10 +: 10] = (s == 0) ? 10'd0 : (s < 15) ? 10'd1 : (s < 18) ? 10'd2 : 10'd3;
    end
    return d;
  endfunction

  task automatic go0(input int iv, input logic [479:0] d);
    @(negedge clk);
    chk("ready0_before", int'(ir0), 1);
    init0 = 10'(iv); divs0 = d; iv0 = 1'b1;
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic fin0(input string tag, input int iv, input logic [479:0] d);
    int r, z, cyc, chg;
    logic [9:0] hold;
    model(iv, d, 48, r, z);
    hold = res0; cyc = 0; chg = 0;
    while (!ov0 && cyc < 1000) begin
      @(negedge clk); cyc++;
      if (!ov0 && res0 !== hold) chg++;
    end
    chk({tag, "_lat"}, cyc, 480);
    chk({tag, "_res"}, int'(res0), r);
    chk({tag, "_dz"}, int'(dz0), z);
    chk({tag, "_held"}, chg, 0);
    or0 = 1'b1;
    @(negedge clk);
    or0 = 1'b0;
    chk({tag, "_ov_after"}, int'(ov0), 0);
    chk({tag, "_rdy_after"}, int'(ir0), 1);
  endtask

  task automatic go3(input int iv, input logic [479:0] d);
    @(negedge clk);
    chk("ready3_before", int'(ir3), 1);
    init3 = 10'(iv); divs3 = d[29:0]; iv3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
  endtask

  task automatic fin3(input string tag, input int iv, input logic [479:0] d, input bit ack);
    int r, z, cyc, chg;
    logic [9:0] hold;
    iv3 = 1'b0;
    model(iv, d, 3, r, z);
    hold = res3; cyc = 0; chg = 0;
    while (!ov3 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (!ov3 && res3 !== hold) chg++;
    end
    chk({tag, "_lat"}, cyc, 30);
    chk({tag, "_res"}, int'(res3), r);
    chk({tag, "_dz"}, int'(dz3), z);
    chk({tag, "_held"}, chg, 0);
    if (ack) begin
      or3 = 1'b1;
      @(negedge clk);
      or3 = 1'b0;
      chk({tag, "_ov_after"}, int'(ov3), 0);
      chk({tag, "_rdy_after"}, int'(ir3), 1);
    end
  endtask

  initial begin
    logic [479:0] d;
    int iv, rh, zh;
    rst0 = 1; rst3 = 1; iv0 = 0; iv3 = 0; or0 = 0; or3 = 0;
    init0 = '0; init3 = '0; divs0 = '0; divs3 = '0;
    repeat (3) @(negedge clk);
    rst0 = 0; rst3 = 0;
    chk("rst_ready0", int'(ir0), 1);  chk("rst_valid0", int'(ov0), 0);
    chk("rst_res0", int'(res0), 0);   chk("rst_dz0", int'(dz0), 0);
    chk("rst_ready3", int'(ir3), 1);  chk("rst_valid3", int'(ov3), 0);
    chk("rst_res3", int'(res3), 0);   chk("rst_dz3", int'(dz3), 0);

    // three-slice directed cases
    d = pk3(2, 4, 5); go3(1000, d); fin3("n3_div", 1000, d, 1'b1);
    d = pk3(0, 3, 1); go3(7, d);    fin3("n3_zero", 7, d, 1'b1);
    d = pk3(9, 1, 1); go3(3, d);    fin3("n3_small", 3, d, 1'b1);
    for (int i = 0; i < 6; i++) begin
      d = pk3(int'($urandom_range(0, 12)), int'($urandom_range(0, 5)), int'($urandom_range(0, 1023)));
      iv = int'($urandom_range(0, 1023));
      go3(iv, d); fin3("n3_rand", iv, d, 1'b1);
    end

    // back-pressure in DONE while inputs churn
    d = pk3(0, 3, 1); go3(7, d); fin3("bp_tx", 7, d, 1'b0);
    rh = int'(res3); zh = int'(dz3);
    for (int i = 0; i < 20; i++) begin
      iv3 = 1'b1; init3 = 10'($urandom); divs3 = 30'($urandom);
      @(negedge clk);
      chk("bp_res", int'(res3), rh);  chk("bp_dz", int'(dz3), zh);
      chk("bp_ready", int'(ir3), 0);  chk("bp_valid", int'(ov3), 1);
    end
    d = pk3(5, 2, 1);
    init3 = 10'd500; divs3 = d[29:0]; iv3 = 1'b1; or3 = 1'b1;
    @(negedge clk);
    or3 = 1'b0;
    chk("bp_idle_ready", int'(ir3), 1);
    chk("bp_idle_valid", int'(ov3), 0);
    @(negedge clk);
    chk("bp_next_accept", int'(ir3), 0);
    fin3("bp_next", 500, d, 1'b1);

    // default 48-slice instance
    d = ones48(); go0(1000, d); fin0("n48_ones", 1000, d);
    d = ones48(); d[479:470] = 10'd0; go0(5, d); fin0("n48_lastzero", 5, d);
    for (int i = 0; i < 3; i++) begin
      d = rnd48(); iv = int'($urandom_range(0, 1023));
      go0(iv, d); fin0("n48_rand", iv, d);
    end

    // reset in the middle of a division
    d = ones48(); go0(777, d);
    repeat (99) @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    chk("midrst_ready", int'(ir0), 1);  chk("midrst_valid", int'(ov0), 0);
    chk("midrst_res", int'(res0), 0);   chk("midrst_dz", int'(dz0), 0);
    d = ones48(); go0(1000, d); fin0("n48_after_rst", 1000, d);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
